alu_wb_collect: RTL and testbench
=================================

Name: alu_wb_collect

Overview:
- Writeback-side receiver for the ALU result and branch-commit interfaces.
- Accepts up to NALU registered ALU result beats per cycle and writes them into the commit-slot result store. Maintains per-slot done bits.
- Latches the oldest ALU-reported branch mispredict and releases a single fetch redirect once that slot reaches the commit head.
- Sits between the ALU array and the commit/retire stage.

Parameters:
- NALU, 2, number of ALU result ports
- RV, 64, register width
- NCOMMIT, 32, commit slots (power of 2)
- LNCOMMIT, 5, log2(NCOMMIT)
- BDEC, 4, branch decode bits carried with a redirect

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- res  in  NALU*RV  ALU results, port i at [i*RV +: RV]
- res_rd  in  NALU*LNCOMMIT  destination commit slot per port
- res_makes_rd  in  NALU  per-port write valid (hart 0)
- alu_br_enable  in  1  ALU branch mispredict/redirect valid
- alu_br  in  RV-1  new PC [RV-1:1]
- alu_br_addr  in  LNCOMMIT  commit slot of the branch
- alu_br_short  in  1  branch was a 16-bit instruction
- alu_br_dec  in  BDEC-1  branch PC low bits [BDEC-1:1]
- commit_head  in  LNCOMMIT  oldest live commit slot
- commit_retire  in  1  head slot retires this cycle
- commit_kill  in  NCOMMIT  per-slot flush mask
- rd_addr  in  LNCOMMIT  commit-stage read address
- rd_data  out  RV  stored result for rd_addr (registered)
- commit_done  out  NCOMMIT  per-slot result-written flags
- redirect_valid  out  1  one-cycle fetch redirect pulse
- redirect_pc  out  RV-1  redirect target [RV-1:1]
- redirect_addr  out  LNCOMMIT  slot that caused the redirect
- redirect_short  out  1  copy of the held short flag
- redirect_dec  out  BDEC-1  copy of the held dec bits

Behaviour:
- Reset (reset==0 at a clk edge):
  - commit_done=0, redirect_valid=0, FSM=IDLE, rd_data=0.
  - Held branch fields are zeroed.
  - Storage contents are don't-care.
- Write: for each i with res_makes_rd[i]:
  - store[res_rd_i] <= res_i and done[res_rd_i] <= 1 at the next edge.
  - Two ports targeting the same slot in one cycle is illegal; the higher index wins deterministically.
- Done-bit clear priority, highest first: reset, commit_kill[s], retire (s==commit_head && commit_retire), then write.
  - A write to a slot killed in the same cycle leaves done=0.
  - A retire and a write to the same slot in the same cycle clears done.
- Read: rd_data <= store[rd_addr], 1-cycle latency. A same-cycle write to rd_addr returns the new data (write-first bypass).
- Age: age(s) = (s - commit_head) mod NCOMMIT; smaller is older.
- FSM:
  - IDLE: on alu_br_enable, and if commit_kill[alu_br_addr]==0, latch all br fields and go to HELD.
  - HELD:
    - If commit_kill[held_addr]: go to IDLE (a new alu_br in the same cycle is still evaluated and may be latched).
    - Else if alu_br_enable with age(alu_br_addr) < age(held_addr): replace the held fields.
    - Else if held_addr==commit_head && done[held_addr]: go to FIRE.
  - FIRE: redirect_valid=1 for exactly one cycle with the held fields, then go to IDLE.
    - An alu_br arriving during FIRE is latched directly and goes to HELD.
- redirect_* outputs hold their last values when not valid; consumers must use them only when redirect_valid=1.
- redirect_valid is registered, driven only from the FIRE state.
- Reset asserted mid-HELD or mid-FIRE: the redirect is dropped with no pulse.
- commit_head wrap from NCOMMIT-1 to 0 is handled by the modular age arithmetic only; there is no special case.

Decomposition:
- Shared package:
  - commit-slot index typedef (LNCOMMIT bits)
  - branch-redirect struct {pc, addr, short, dec}
  - FSM state enum {IDLE, HELD, FIRE}
  - age-compare function older(a, b, head)
- One sub-module: alu_wb_store.
  - NCOMMIT x RV storage with NALU write ports and one registered read port.
  - Includes the write-first bypass.
- Done bits and the FSM stay in the top level.

Test Plan:
1. Write and read back: port0 writes slot 3 = 0xDEAD_BEEF_0000_0001 → commit_done[3]=1 next cycle; rd_addr=3 → rd_data shows that value one cycle later. Then read slot 7 in the same cycle port1 writes it with 0x55 → rd_data=0x55 (bypass).
2. Kill vs write: port0 writes slot 5 while commit_kill[5]=1 → commit_done[5] stays 0. Retire slot 5 when head=5 after a legal write → done[5] clears.
3. Basic redirect: head=2; alu_br slot 4, pc=0x1000>>1; write slot 4; advance head to 4 → redirect_valid exactly one cycle, redirect_pc=0x800, redirect_addr=4.
4. Older replaces younger: head=30; branch at slot 1 held, then branch at slot 31 arrives → held_addr=31. Head reaching 31 with done → fires 31 only, not 1.
5. Killed held branch: branch held at slot 9; commit_kill[9]=1 → FSM returns to IDLE, and no redirect pulse occurs even when head later reaches 9.
6. Reset mid-operation: FSM in HELD; drive reset=0 for one edge → commit_done=0, redirect_valid=0. After release, head passing the old slot gives no redirect.

Source files
------------

// File: rtl/alu_wb_collect_pkg.sv
// Shared types and helpers for the ALU writeback collector.
//   slot_t   : commit-slot index
//   br_t     : branch redirect record {pc, addr, is_short, dec}
//   state_t  : redirect FSM state
//   older()  : age compare relative to the commit head
package alu_wb_collect_pkg;

  localparam int NALU     = 2;
  localparam int RV       = 64;
  localparam int NCOMMIT  = 32;
  localparam int LNCOMMIT = 5;
  localparam int BDEC     = 4;

  typedef logic [LNCOMMIT-1:0] slot_t;

  typedef struct packed {
    logic [RV-2:0]   pc;
    slot_t           addr;
    logic            is_short;
    logic [BDEC-2:0] dec;
  } br_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_FIRE
  } state_t;

  // True when slot a is strictly older than slot b. The LNCOMMIT-bit
  // subtraction wraps naturally, so head wrap needs no special case.
  function automatic logic older(slot_t a, slot_t b, slot_t head);
    slot_t age_a;
    slot_t age_b;
    age_a = a - head;
    age_b = b - head;
    return age_a < age_b;
  endfunction

endpackage

// File: rtl/alu_wb_store.sv
// Commit-slot result store: NCOMMIT x RV entries, NALU write ports and one
// registered read port with write-first bypass.
// Ports:
//   clk, reset  : clock, synchronous active-low reset (read register only)
//   wr_data     : NALU packed write data, port i at [i*RV +: RV]
//   wr_addr     : NALU packed slot indices
//   wr_en       : per-port write enable
//   rd_addr     : read slot
//   rd_data     : store[rd_addr], one cycle later
module alu_wb_store
  import alu_wb_collect_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NALU*RV-1:0]       wr_data,
  input  logic [NALU*LNCOMMIT-1:0] wr_addr,
  input  logic [NALU-1:0]          wr_en,
  input  logic [LNCOMMIT-1:0]      rd_addr,
  output logic [RV-1:0]            rd_data
);

  logic [RV-1:0] mem [NCOMMIT];
  logic [RV-1:0] rd_next;
  logic [RV-1:0] rd_p1;

  // Later ports overwrite earlier ones, so the highest index wins a collision.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NALU; i++) begin
      if (wr_en[i]) begin
        mem[wr_addr[i*LNCOMMIT +: LNCOMMIT]] <= wr_data[i*RV +: RV];
      end
    end
  end

  always_comb begin
    rd_next = mem[rd_addr];
    for (int i = 0; i < NALU; i++) begin
      if (wr_en[i] && (wr_addr[i*LNCOMMIT +: LNCOMMIT] == rd_addr)) begin
        rd_next = wr_data[i*RV +: RV];
      end
    end
  end

  // ---- stage p1: registered read ----
  always_ff @(posedge clk) begin
    if (!reset) rd_p1 <= '0;
    else        rd_p1 <= rd_next;
  end

  assign rd_data = rd_p1;

endmodule

// File: rtl/alu_wb_collect.sv
// Writeback collector: stores ALU results per commit slot, tracks per-slot
// done bits and holds the oldest branch mispredict until its slot reaches
// the commit head, then emits a single fetch redirect pulse.
// Ports:
//   clk, reset           : clock, synchronous active-low reset
//   res/res_rd/res_makes_rd : NALU result beats (data, slot, valid)
//   alu_br_*             : branch redirect report (pc, slot, short, dec)
//   commit_head/retire   : oldest live slot and its retire strobe
//   commit_kill          : per-slot flush mask
//   rd_addr/rd_data      : registered result read port
//   commit_done          : per-slot result-written flags
//   redirect_*           : one-cycle redirect pulse and its held fields
module alu_wb_collect
  import alu_wb_collect_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NALU*RV-1:0]       res,
  input  logic [NALU*LNCOMMIT-1:0] res_rd,
  input  logic [NALU-1:0]          res_makes_rd,
  input  logic                     alu_br_enable,
  input  logic [RV-2:0]            alu_br,
  input  logic [LNCOMMIT-1:0]      alu_br_addr,
  input  logic                     alu_br_short,
  input  logic [BDEC-2:0]          alu_br_dec,
  input  logic [LNCOMMIT-1:0]      commit_head,
  input  logic                     commit_retire,
  input  logic [NCOMMIT-1:0]       commit_kill,
  input  logic [LNCOMMIT-1:0]      rd_addr,
  output logic [RV-1:0]            rd_data,
  output logic [NCOMMIT-1:0]       commit_done,
  output logic                     redirect_valid,
  output logic [RV-2:0]            redirect_pc,
  output logic [LNCOMMIT-1:0]      redirect_addr,
  output logic                     redirect_short,
  output logic [BDEC-2:0]          redirect_dec
);

  alu_wb_store u_store (
    .clk     (clk),
    .reset   (reset),
    .wr_data (res),
    .wr_addr (res_rd),
    .wr_en   (res_makes_rd),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  logic [NCOMMIT-1:0] done_p1;
  logic [NCOMMIT-1:0] done_next;

  // Applied lowest priority first: write sets, retire clears, kill clears.
  always_comb begin
    done_next = done_p1;
    for (int i = 0; i < NALU; i++) begin
      if (res_makes_rd[i]) done_next[res_rd[i*LNCOMMIT +: LNCOMMIT]] = 1'b1;
    end
    if (commit_retire) done_next[commit_head] = 1'b0;
    done_next = done_next & ~commit_kill;
  end

  // ---- stage p1: done bits ----
  always_ff @(posedge clk) begin
    if (!reset) done_p1 <= '0;
    else        done_p1 <= done_next;
  end

  assign commit_done = done_p1;

  br_t    br_in;
  br_t    held_p1;
  br_t    held_next;
  br_t    rdr_p1;
  br_t    rdr_next;
  state_t state_p1;
  state_t state_next;
  logic   valid_p1;
  logic   br_live;
  logic   held_killed;

  always_comb begin
    br_in.pc       = alu_br;
    br_in.addr     = alu_br_addr;
    br_in.is_short = alu_br_short;
    br_in.dec      = alu_br_dec;
  end

  assign br_live     = alu_br_enable && !commit_kill[alu_br_addr];
  assign held_killed = commit_kill[held_p1.addr];

  always_comb begin
    state_next = state_p1;
    held_next  = held_p1;
    rdr_next   = rdr_p1;
    case (state_p1)
      // FIRE lasts one cycle; both it and IDLE may capture a fresh branch.
      ST_IDLE, ST_FIRE: begin
        state_next = ST_IDLE;
        if (br_live) begin
          held_next  = br_in;
          state_next = ST_HELD;
        end
      end
      ST_HELD: begin
        if (held_killed) begin
          state_next = ST_IDLE;
          if (br_live) begin
            held_next  = br_in;
            state_next = ST_HELD;
          end
        end else if (alu_br_enable && older(alu_br_addr, held_p1.addr, commit_head)) begin
          held_next = br_in;
        end else if ((held_p1.addr == commit_head) && done_p1[held_p1.addr]) begin
          state_next = ST_FIRE;
          rdr_next   = held_p1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---- stage p1: FSM, held branch and redirect outputs ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_p1 <= ST_IDLE;
      held_p1  <= '0;
      rdr_p1   <= '0;
      valid_p1 <= 1'b0;
    end else begin
      state_p1 <= state_next;
      held_p1  <= held_next;
      rdr_p1   <= rdr_next;
      valid_p1 <= (state_next == ST_FIRE);
    end
  end

  assign redirect_valid = valid_p1;
  assign redirect_pc    = rdr_p1.pc;
  assign redirect_addr  = rdr_p1.addr;
  assign redirect_short = rdr_p1.is_short;
  assign redirect_dec   = rdr_p1.dec;

endmodule

// File: tb/tb_alu_wb_collect.sv
`timescale 1ns/1ps
module tb_alu_wb_collect;
  import alu_wb_collect_pkg::*;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NALU*RV-1:0]       res;
  logic [NALU*LNCOMMIT-1:0] res_rd;
  logic [NALU-1:0]          res_makes_rd;
  logic                     alu_br_enable;
  logic [RV-2:0]            alu_br;
  logic [LNCOMMIT-1:0]      alu_br_addr;
  logic                     alu_br_short;
  logic [BDEC-2:0]          alu_br_dec;
  logic [LNCOMMIT-1:0]      commit_head;
  logic                     commit_retire;
  logic [NCOMMIT-1:0]       commit_kill;
  logic [LNCOMMIT-1:0]      rd_addr;
  logic [RV-1:0]            rd_data;
  logic [NCOMMIT-1:0]       commit_done;
  logic                     redirect_valid;
  logic [RV-2:0]            redirect_pc;
  logic [LNCOMMIT-1:0]      redirect_addr;
  logic                     redirect_short;
  logic [BDEC-2:0]          redirect_dec;

  int n_checks = 0;
  int n_fail   = 0;

  alu_wb_collect dut (
    .clk(clk), .reset(reset), .res(res), .res_rd(res_rd), .res_makes_rd(res_makes_rd),
    .alu_br_enable(alu_br_enable), .alu_br(alu_br), .alu_br_addr(alu_br_addr),
    .alu_br_short(alu_br_short), .alu_br_dec(alu_br_dec), .commit_head(commit_head),
    .commit_retire(commit_retire), .commit_kill(commit_kill), .rd_addr(rd_addr),
    .rd_data(rd_data), .commit_done(commit_done), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_addr(redirect_addr),
    .redirect_short(redirect_short), .redirect_dec(redirect_dec)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we0;
    logic [4:0]  s0;
    logic [63:0] d0;
    logic        we1;
    logic [4:0]  s1;
    logic [63:0] d1;
    logic [31:0] kill;
    logic [4:0]  head;
    logic        retire;
    logic [4:0]  rd;
    logic [63:0] exp_rd;
    logic [4:0]  chk;
    logic        exp_done;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    res           = '0;
    res_rd        = '0;
    res_makes_rd  = '0;
    alu_br_enable = 1'b0;
    alu_br        = '0;
    alu_br_addr   = '0;
    alu_br_short  = 1'b0;
    alu_br_dec    = '0;
    commit_retire = 1'b0;
    commit_kill   = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic set_wr(input int p, input logic [4:0] s, input logic [63:0] d);
    res_makes_rd[p]               = 1'b1;
    res_rd[p*LNCOMMIT +: LNCOMMIT] = s;
    res[p*RV +: RV]               = d;
  endtask

  task automatic set_br(input logic [4:0] s, input logic [62:0] pc, input logic sh,
                        input logic [2:0] dec);
    alu_br_enable = 1'b1;
    alu_br_addr   = s;
    alu_br        = pc;
    alu_br_short  = sh;
    alu_br_dec    = dec;
  endtask

  task automatic watch(input int n, output int pulses, output logic [62:0] pc,
                       output logic [4:0] addr);
    pulses = 0;
    pc     = '0;
    addr   = '0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (redirect_valid) begin
        pulses++;
        pc   = redirect_pc;
        addr = redirect_addr;
      end
    end
  endtask

  function automatic int age_of(int s, int h);
    return (s - h + NCOMMIT) % NCOMMIT;
  endfunction

  // Reference model state
  logic [63:0] m_store [NCOMMIT];
  bit          m_known [NCOMMIT];
  logic [31:0] m_done;
  bit          m_pending;
  bit          m_firing;
  br_t         m_held;
  br_t         m_out;

  initial begin
    int          pulses;
    logic [62:0] wpc;
    logic [4:0]  waddr;
    int          fires;

    rd_addr     = '0;
    commit_head = '0;
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;

    check("reset commit_done", 64'(commit_done), 64'd0);
    check("reset redirect_valid", 64'(redirect_valid), 64'd0);
    check("reset rd_data", rd_data, 64'd0);
    check("reset redirect_pc", 64'(redirect_pc), 64'd0);

    // write/read, bypass, kill, retire and port-priority vectors
    vt[0] = '{1'b1, 5'd3, 64'hDEAD_BEEF_0000_0001, 1'b0, 5'd0, 64'd0, 32'h0, 5'd0, 1'b0,
              5'd3, 64'hDEAD_BEEF_0000_0001, 5'd3, 1'b1};
    vt[1] = '{1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 32'h0, 5'd0, 1'b0,
              5'd3, 64'hDEAD_BEEF_0000_0001, 5'd3, 1'b1};
    vt[2] = '{1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h55, 32'h0, 5'd0, 1'b0,
              5'd7, 64'h55, 5'd7, 1'b1};
    vt[3] = '{1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0, 32'h20, 5'd0, 1'b0,
              5'd7, 64'h55, 5'd5, 1'b0};
    vt[4] = '{1'b1, 5'd5, 64'hAAAA, 1'b0, 5'd0, 64'd0, 32'h0, 5'd0, 1'b0,
              5'd5, 64'hAAAA, 5'd5, 1'b1};
    vt[5] = '{1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 32'h0, 5'd5, 1'b1,
              5'd5, 64'hAAAA, 5'd5, 1'b0};
    vt[6] = '{1'b1, 5'd9, 64'h111, 1'b1, 5'd9, 64'h222, 32'h0, 5'd0, 1'b0,
              5'd9, 64'h222, 5'd9, 1'b1};
    vt[7] = '{1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 32'h0, 5'd0, 1'b0,
              5'd9, 64'h222, 5'd9, 1'b1};
    vt[8] = '{1'b1, 5'd9, 64'h333, 1'b0, 5'd0, 64'd0, 32'h0, 5'd9, 1'b1,
              5'd9, 64'h333, 5'd9, 1'b0};
    vt[9] = '{1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 32'h8, 5'd0, 1'b0,
              5'd3, 64'hDEAD_BEEF_0000_0001, 5'd3, 1'b0};

    for (int i = 0; i < 10; i++) begin
      clear_inputs();
      if (vt[i].we0) set_wr(0, vt[i].s0, vt[i].d0);
      if (vt[i].we1) set_wr(1, vt[i].s1, vt[i].d1);
      commit_kill   = vt[i].kill;
      commit_head   = vt[i].head;
      commit_retire = vt[i].retire;
      rd_addr       = vt[i].rd;
      tick();
      check($sformatf("vec%0d rd_data", i), rd_data, vt[i].exp_rd);
      check($sformatf("vec%0d done", i), 64'(commit_done[vt[i].chk]), 64'(vt[i].exp_done));
    end
    clear_inputs();

    // basic redirect
    commit_head = 5'd2;
    do_reset();
    set_br(5'd4, 63'h800, 1'b0, 3'd2);
    tick();
    clear_inputs();
    set_wr(0, 5'd4, 64'h44);
    tick();
    clear_inputs();
    check("basic no early redirect", 64'(redirect_valid), 64'd0);
    check("basic done4", 64'(commit_done[4]), 64'd1);
    commit_head = 5'd4;
    watch(6, pulses, wpc, waddr);
    check("basic pulse count", 64'(pulses), 64'd1);
    check("basic redirect_pc", 64'(wpc), 64'h800);
    check("basic redirect_addr", 64'(waddr), 64'd4);
    check("basic pc holds", 64'(redirect_pc), 64'h800);

    // older branch replaces younger across head wrap
    commit_head = 5'd30;
    do_reset();
    set_br(5'd1, 63'h111, 1'b0, 3'd1);
    tick();
    clear_inputs();
    set_wr(0, 5'd1, 64'h1);
    set_wr(1, 5'd31, 64'h31);
    tick();
    clear_inputs();
    set_br(5'd31, 63'h31F, 1'b1, 3'd5);
    tick();
    clear_inputs();
    commit_head = 5'd31;
    watch(6, pulses, wpc, waddr);
    check("older pulse count", 64'(pulses), 64'd1);
    check("older redirect_addr", 64'(waddr), 64'd31);
    check("older redirect_pc", 64'(wpc), 64'h31F);
    check("older short/dec", 64'({redirect_short, redirect_dec}), 64'({1'b1, 3'd5}));
    commit_head = 5'd1;
    watch(6, pulses, wpc, waddr);
    check("younger never fires", 64'(pulses), 64'd0);

    // killed held branch
    commit_head = 5'd0;
    do_reset();
    set_br(5'd9, 63'h999, 1'b0, 3'd0);
    tick();
    clear_inputs();
    set_wr(0, 5'd9, 64'h9);
    tick();
    clear_inputs();
    commit_kill[9] = 1'b1;
    tick();
    clear_inputs();
    check("kill clears done9", 64'(commit_done[9]), 64'd0);
    set_wr(0, 5'd9, 64'h99);
    tick();
    clear_inputs();
    commit_head = 5'd9;
    watch(6, pulses, wpc, waddr);
    check("killed branch no pulse", 64'(pulses), 64'd0);

    // reset while HELD
    commit_head = 5'd0;
    do_reset();
    set_br(5'd12, 63'hC00, 1'b0, 3'd0);
    tick();
    clear_inputs();
    set_wr(0, 5'd12, 64'hC);
    tick();
    clear_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midreset commit_done", 64'(commit_done), 64'd0);
    check("midreset redirect_valid", 64'(redirect_valid), 64'd0);
    set_wr(0, 5'd12, 64'hCC);
    tick();
    clear_inputs();
    commit_head = 5'd12;
    watch(6, pulses, wpc, waddr);
    check("midreset no pulse", 64'(pulses), 64'd0);

    // randomized run against the reference model
    commit_head = 5'd0;
    rd_addr     = 5'd0;
    do_reset();
    for (int s = 0; s < NCOMMIT; s++) begin
      m_known[s] = 1'b0;
      m_store[s] = '0;
    end
    m_done    = '0;
    m_pending = 1'b0;
    m_firing  = 1'b0;
    m_held    = '0;
    m_out     = '0;
    fires     = 0;

    for (int c = 0; c < 800; c++) begin
      logic [63:0] e_rd;
      bit          e_known;
      logic [31:0] nd;
      br_t         br;
      logic [4:0]  s0;
      logic [4:0]  s1;

      if (commit_retire) commit_head = commit_head + 5'd1;
      clear_inputs();
      for (int p = 0; p < NALU; p++) begin
        if ($urandom_range(1, 0) == 1) set_wr(p, 5'($urandom_range(31, 0)), {$urandom, $urandom});
      end
      s0 = res_rd[4:0];
      s1 = res_rd[9:5];
      if (res_makes_rd == 2'b11 && s0 == s1) res_makes_rd[0] = 1'b0;
      if ($urandom_range(9, 0) == 0) commit_kill[$urandom_range(31, 0)] = 1'b1;
      commit_retire = ($urandom_range(2, 0) == 0);
      if ($urandom_range(4, 0) == 0)
        set_br(commit_head + 5'($urandom_range(12, 0)), {$urandom, $urandom} >> 1,
               1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)));
      rd_addr = 5'($urandom_range(31, 0));

      // expected read
      if (res_makes_rd[1] && s1 == rd_addr) begin
        e_rd = res[127:64]; e_known = 1'b1;
      end else if (res_makes_rd[0] && s0 == rd_addr) begin
        e_rd = res[63:0]; e_known = 1'b1;
      end else begin
        e_rd = m_store[rd_addr]; e_known = m_known[rd_addr];
      end

      // expected done bits
      for (int s = 0; s < NCOMMIT; s++) begin
        bit wr;
        wr = (res_makes_rd[0] && s0 == 5'(s)) || (res_makes_rd[1] && s1 == 5'(s));
        if (commit_kill[s])                                nd[s] = 1'b0;
        else if (commit_retire && commit_head == 5'(s))    nd[s] = 1'b0;
        else if (wr)                                       nd[s] = 1'b1;
        else                                               nd[s] = m_done[s];
      end

      // expected redirect behaviour
      br.pc = alu_br; br.addr = alu_br_addr; br.is_short = alu_br_short; br.dec = alu_br_dec;
      if (m_firing || !m_pending || commit_kill[m_held.addr]) begin
        m_firing  = 1'b0;
        m_pending = 1'b0;
        if (alu_br_enable && !commit_kill[alu_br_addr]) begin
          m_pending = 1'b1;
          m_held    = br;
        end
      end else if (alu_br_enable &&
                   age_of(int'(alu_br_addr), int'(commit_head)) <
                   age_of(int'(m_held.addr), int'(commit_head))) begin
        m_held = br;
      end else if (m_held.addr == commit_head && m_done[m_held.addr]) begin
        m_firing  = 1'b1;
        m_pending = 1'b0;
        m_out     = m_held;
      end

      if (res_makes_rd[0]) begin m_store[s0] = res[63:0];   m_known[s0] = 1'b1; end
      if (res_makes_rd[1]) begin m_store[s1] = res[127:64]; m_known[s1] = 1'b1; end
      m_done = nd;

      tick();
      check("rand commit_done", 64'(commit_done), 64'(m_done));
      check("rand redirect_valid", 64'(redirect_valid), 64'(m_firing));
      if (m_firing) begin
        fires++;
        check("rand redirect_pc", 64'(redirect_pc), 64'(m_out.pc));
        check("rand redirect fields", 64'({redirect_addr, redirect_short, redirect_dec}),
              64'({m_out.addr, m_out.is_short, m_out.dec}));
      end
      if (e_known) check("rand rd_data", rd_data, e_rd);
    end
    $display("random phase redirects observed: %0d", fires);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
